// File: rtl/pipelined_cla_alu_adder_pkg.sv
// Shared constants and mode encoding for the pipelined CLA adder/subtractor.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_BLOCK = 8;
    localparam int unsigned ALU_TAG_W = 6;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } alu_mode_e;

endpackage

// File: rtl/pipelined_cla_alu_adder_cla_group.sv
// Combinational BLOCK-bit carry-lookahead group with flattened carry terms.
module cla_group #(
    parameter int unsigned BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is the OR of every generate term propagated up to it, plus cin.
    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int unsigned j = i; j > 0; j--) begin
                acc = acc | (g[j-1] & pp);
                pp  = pp & p[j-1];
            end
            c[i+1] = acc | (cin & pp);
        end
    end

    assign sum   = p ^ c[BLOCK-1:0];
    assign cout  = c[BLOCK];
    assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_alu_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit group per stage,
// tag pass-through, flush, and valid/ready backpressure on the result side.
module pipelined_cla_alu_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned BLOCK = ALU_BLOCK,
    parameter int unsigned TAG_W = ALU_TAG_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned NG = WIDTH / BLOCK;

    logic stall;
    logic accept;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready & ~flush;

    for (genvar gi = 0; gi < NG; gi++) begin : stg
        localparam int unsigned LO   = gi * BLOCK;
        localparam int unsigned DONE = (gi + 1) * BLOCK;
        localparam int unsigned REM  = WIDTH - DONE;

        // Operands still to be consumed; the current group sits in the low bits.
        logic [WIDTH-LO-1:0] a_i;
        logic [WIDTH-LO-1:0] b_i;
        logic                c_i;
        logic                v_i;
        logic [TAG_W-1:0]    t_i;
        logic [DONE-1:0]     sum_n;
        logic [BLOCK-1:0]    gs;
        logic                gc;
        logic                gm;

        if (gi == 0) begin : head
            assign a_i   = in_a;
            assign b_i   = (alu_mode_e'(in_sub) == SUB) ? ~in_b : in_b;
            assign c_i   = in_sub;
            assign v_i   = accept;
            assign t_i   = in_tag;
            assign sum_n = gs;
        end else begin : body
            assign a_i   = stg[gi-1].mid.r_a;
            assign b_i   = stg[gi-1].mid.r_b;
            assign c_i   = stg[gi-1].mid.r_c;
            assign v_i   = stg[gi-1].mid.r_v;
            assign t_i   = stg[gi-1].mid.r_tag;
            assign sum_n = {gs, stg[gi-1].mid.r_sum};
        end

        cla_group #(
            .BLOCK (BLOCK)
        ) u_grp (
            .a     (a_i[BLOCK-1:0]),
            .b     (b_i[BLOCK-1:0]),
            .cin   (c_i),
            .sum   (gs),
            .cout  (gc),
            .c_msb (gm)
        );

        if (gi < NG - 1) begin : mid
            logic [REM-1:0]   r_a;
            logic [REM-1:0]   r_b;
            logic             r_c;
            logic             r_v;
            logic [DONE-1:0]  r_sum;
            logic [TAG_W-1:0] r_tag;

            // Inter-stage register: holds on stall, valid cleared by flush.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_c   <= 1'b0;
                    r_v   <= 1'b0;
                    r_sum <= '0;
                    r_tag <= '0;
                end else begin
                    if (!stall) begin
                        r_a   <= a_i[WIDTH-LO-1:BLOCK];
                        r_b   <= b_i[WIDTH-LO-1:BLOCK];
                        r_c   <= gc;
                        r_sum <= sum_n;
                        r_tag <= t_i;
                    end
                    r_v <= flush ? 1'b0 : (stall ? r_v : v_i);
                end
            end
        end else begin : last
            // Output register: flags are derived from the fully assembled sum.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    out_sum   <= '0;
                    out_cout  <= 1'b0;
                    out_ovf   <= 1'b0;
                    out_zero  <= 1'b1;
                    out_tag   <= '0;
                    out_valid <= 1'b0;
                end else begin
                    if (!stall) begin
                        out_sum  <= sum_n;
                        out_cout <= gc;
                        out_ovf  <= gm ^ gc;
                        out_zero <= ~|sum_n;
                        out_tag  <= t_i;
                    end
                    out_valid <= flush ? 1'b0 : (stall ? out_valid : v_i);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_alu_adder.sv
// Scoreboard bench for pipelined_cla_alu_adder with directed vectors.
module tb_pipelined_cla_alu_adder;
    import alu_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned B  = 8;
    localparam int unsigned T  = 6;
    localparam int unsigned NG = W / B;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic [T-1:0] tag;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic [T-1:0] in_tag;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;
    logic [T-1:0] out_tag;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    pipelined_cla_alu_adder #(
        .WIDTH (W),
        .BLOCK (B),
        .TAG_W (T)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [T-1:0] tag, input logic [W-1:0] es,
                         input logic ec, input logic eo, input logic ez);
        int unsigned k = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_tag   = tag;
        #4;
        while (!in_ready && k < 50) begin
            @(negedge clock);
            #4;
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout tag %0d: in_ready got 0, required 1", tag);
            in_valid = 1'b0;
        end else begin
            sb.push_back('{sum: es, cout: ec, ovf: eo, zero: ez, tag: tag});
        end
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        repeat (2) @(negedge clock);
        check(name, sb.size(), 0);
    endtask

    // Monitor: compares the head of the scoreboard whenever a result is
    // presented (every stalled cycle too), pops only on consumption.
    always @(negedge clock) begin
        #4;
        if (!reset_n) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_result: got tag %0d sum %h, required no valid output",
                             out_tag, out_sum);
                end else begin
                    e = sb[0];
                    if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf ||
                        out_zero !== e.zero || out_tag !== e.tag) begin
                        n_bad++;
                        $display("FAIL result tag %0d: got sum=%h cout=%b ovf=%b zero=%b tag=%0d, required sum=%h cout=%b ovf=%b zero=%b tag=%0d",
                                 e.tag, out_sum, out_cout, out_ovf, out_zero, out_tag,
                                 e.sum, e.cout, e.ovf, e.zero, e.tag);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (flush) sb.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned k;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum",   out_sum,   0);
        check("rst_out_tag",   out_tag,   0);
        check("rst_out_cout",  out_cout,  0);
        check("rst_out_ovf",   out_ovf,   0);
        check("rst_out_zero",  out_zero,  1);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Arithmetic vectors, issued back to back.
        issue(32'h0000_00FF, 32'h0000_0001, ADD,  5, 32'h0000_0100, 0, 0, 0);
        issue(32'hFFFF_FFFF, 32'h0000_0001, ADD,  6, 32'h0000_0000, 1, 0, 1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, ADD,  7, 32'h8000_0000, 0, 1, 0);
        issue(32'h0000_0005, 32'h0000_0007, SUB,  8, 32'hFFFF_FFFE, 0, 0, 0);
        issue(32'h0000_0007, 32'h0000_0005, SUB,  9, 32'h0000_0002, 1, 0, 0);
        issue(32'h8000_0000, 32'h0000_0001, SUB, 10, 32'h7FFF_FFFF, 1, 1, 0);
        issue(32'h0000_0000, 32'h0000_0000, SUB, 11, 32'h0000_0000, 1, 0, 1);
        issue(32'h1234_5678, 32'h9ABC_DEF0, ADD, 12, 32'hACF1_3568, 0, 0, 0);
        idle();
        drain("drain_arith");

        // Backpressure: six ops, consumer stalls for three cycles.
        fork
            begin
                issue(32'h0000_0001, 32'h0000_0001, ADD, 1, 32'h0000_0002, 0, 0, 0);
                issue(32'h0000_0002, 32'h0000_0003, ADD, 2, 32'h0000_0005, 0, 0, 0);
                issue(32'h0000_000A, 32'h0000_0004, SUB, 3, 32'h0000_0006, 1, 0, 0);
                issue(32'h0000_00F0, 32'h0000_0010, ADD, 4, 32'h0000_0100, 0, 0, 0);
                issue(32'h0000_0000, 32'h0000_0001, SUB, 5, 32'hFFFF_FFFF, 0, 0, 0);
                issue(32'h4000_0000, 32'h4000_0000, ADD, 6, 32'h8000_0000, 0, 1, 0);
                idle();
            end
            begin
                k = 0;
                @(negedge clock);
                #1;
                while (!out_valid && k < 50) begin
                    @(negedge clock);
                    #1;
                    k++;
                end
                check("bp_out_valid_seen", out_valid, 1);
                out_ready = 1'b0;
                repeat (3) begin
                    #3;
                    check("bp_in_ready_stalled", in_ready, 0);
                    @(negedge clock);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Flush kills three in-flight ops and an op offered with the flush.
        issue(32'h0000_0001, 32'h0000_0001, ADD, 1, 32'h0000_0002, 0, 0, 0);
        issue(32'h0000_0001, 32'h0000_0001, ADD, 2, 32'h0000_0002, 0, 0, 0);
        issue(32'h0000_0001, 32'h0000_0001, ADD, 3, 32'h0000_0002, 0, 0, 0);
        @(negedge clock);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = 32'h0000_0009;
        in_b     = 32'h0000_0009;
        in_sub   = ADD;
        in_tag   = 7;
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (2 * NG + 2) @(negedge clock);
        issue(32'h0000_0002, 32'h0000_0002, ADD, 4, 32'h0000_0004, 0, 0, 0);
        idle();
        drain("drain_flush");

        // Asynchronous reset with operations in flight.
        issue(32'h0000_0001, 32'h0000_0002, ADD, 20, 32'h0000_0003, 0, 0, 0);
        issue(32'h0000_0003, 32'h0000_0004, ADD, 21, 32'h0000_0007, 0, 0, 0);
        issue(32'h0000_0005, 32'h0000_0006, ADD, 22, 32'h0000_000B, 0, 0, 0);
        issue(32'h0000_0007, 32'h0000_0008, ADD, 23, 32'h0000_000F, 0, 0, 0);
        @(posedge clock);
        #2;
        check("pre_reset_out_valid", out_valid, 1);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_sum",   out_sum,   0);
        check("async_rst_out_zero",  out_zero,  1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2 * NG) @(negedge clock);
        #4;
        check("post_reset_out_valid", out_valid, 0);
        check("post_reset_in_ready",  in_ready,  1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_alu_adder.md
Name: pipelined_cla_alu_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the integer execute path of the out-of-order core.
- Splits a WIDTH-bit operation into WIDTH/BLOCK lookahead groups, with one group resolved per pipeline stage and a carry register between stages.
- Carries an issue tag, supports flush of in-flight operations, and uses a valid/ready handshake toward the result bus.
- Successor to the fixed 8-bit CLA: adds generic width, subtract mode, flags, pipelining and backpressure.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of BLOCK.
- BLOCK, 8, bits per lookahead group. NG = WIDTH/BLOCK is both the number of stages and the latency.
- TAG_W, 6, width of the reorder-buffer tag passed through with each operation.

Ports:
- clock, in, 1, single clock; rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operation offered.
- in_ready, out, 1, pipeline accepts an operation this cycle.
- in_a, in, WIDTH, operand A.
- in_b, in, WIDTH, operand B.
- in_sub, in, 1, 0 = A+B, 1 = A-B (computed as A + ~B + 1).
- in_tag, in, TAG_W, tag of the operation.
- flush, in, 1, kill every in-flight and incoming operation.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer takes the result.
- out_sum, out, WIDTH, result.
- out_cout, out, 1, carry out of the MSB. For subtraction, 1 means no borrow.
- out_ovf, out, 1, signed overflow = carry into MSB XOR carry out of MSB.
- out_zero, out, 1, out_sum == 0.
- out_tag, out, TAG_W, tag of the result.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All stage valid bits clear, so out_valid = 0.
  - out_sum, out_tag, out_cout, out_ovf = 0; out_zero = 1.
  - in_ready = 1 once reset is deasserted.
  - Reset mid-operation discards everything in flight; no partial result is ever presented.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stalled, every stage register holds.
  - Bubbles are not compressed; the pipeline moves only as a whole.
- Accept: an operation is accepted when in_valid & in_ready & ~flush.
- Stage 0: B' = in_sub ? ~in_b : in_b, and Cin = in_sub.
  - Group 0 (bits BLOCK-1:0) is resolved combinationally.
  - Stage-1 registers capture:
    - the low sum bits;
    - the group carry out;
    - the unconsumed upper bits of A and B';
    - tag and valid.
- Stage k (1 ≤ k < NG):
  - Resolves group k from the registered operand slice and the registered carry.
  - Appends the result to the accumulated sum.
  - Stage NG-1 also captures:
    - carry into the MSB, for ovf;
    - final carry out;
    - zero = ~|sum, evaluated on the full assembled sum before it is registered.
- Output stage:
  - The final registers drive out_* directly; all outputs are registered.
  - Latency from accept to out_valid is exactly NG cycles when not stalled (4 for the defaults).
  - Throughput is one operation per cycle.
- Output handshake:
  - The result is consumed on out_valid & out_ready.
  - The pipeline advances on that same edge, so back-to-back results are possible.
  - While stalled, out_* are held stable.
- Flush:
  - On the next edge, all valid bits clear, including the output stage, even when stalled.
  - An input offered in the same cycle is not accepted.
  - Datapath registers may retain stale values; only valid is meaningful.
- Flush + stall together: flush wins; out_valid = 0 after the edge.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - 0 - 0 gives cout = 1.
  - The most negative value minus 1 sets ovf.
- NG = 1 is legal: the pipeline degenerates to a single registered stage with 1-cycle latency.

Decomposition:
- Shared package (alu_pkg):
  - constants for the default WIDTH, BLOCK and TAG_W;
  - the mode encoding ADD = 0, SUB = 1.
- One sub-module: cla_group.
  - Combinational BLOCK-bit lookahead group.
  - Inputs a, b, cin; outputs sum, cout, and c_msb (carry into the group MSB).
  - Built from per-bit generate/propagate terms with flattened lookahead carries.
  - Instantiated NG times by a generate loop.

Test Plan:
- Basic add, pipeline full: in_a = 0x0000_00FF, in_b = 0x0000_0001, add, tag 5 → 4 cycles later:
  - sum = 0x0000_0100, cout = 0, ovf = 0, zero = 0, tag = 5.
  - The carry crosses the group-0/1 boundary.
- Full carry ripple: 0xFFFF_FFFF + 1 → sum = 0, cout = 1, zero = 1, ovf = 0. Then 0x7FFF_FFFF + 1 → sum = 0x8000_0000, ovf = 1.
- Subtract: 5 - 7 → sum = 0xFFFF_FFFE, cout = 0. 7 - 5 → sum = 2, cout = 1. 0x8000_0000 - 1 → sum = 0x7FFF_FFFF, ovf = 1.
- Backpressure: issue 6 back-to-back ops with tags 1..6; hold out_ready = 0 for 3 cycles while out_valid is 1 →
  - in_ready = 0 during the stall;
  - out_* stable during the stall;
  - all 6 results delivered in tag order 1..6, none lost or duplicated.
- Flush: issue tags 1..3, pulse flush one cycle later → no out_valid for tags 1..3. A new op 2 + 2 issued after the flush → sum = 4 after 4 cycles.
- Async reset mid-flight: assert reset_n = 0 between clock edges with 3 ops in flight → out_valid drops immediately; after release, no stale result appears within 2×NG cycles.
